// File: rtl/cu_pkg.sv
// Shared types and encodings for the pipelined ARM-subset control unit.
package cu_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_MUL = 3'd5;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  typedef enum logic {IDLE, BUSY} mul_state_t;

  // ALUControl is kept at its native 3 bits; the top zero-extends it.
  typedef struct packed {
    logic       RegWrite;
    logic       MemWrite;
    logic       MemtoReg;
    logic       ALUSrc;
    logic       Branch;
    logic [1:0] FlagWrite;
    logic [2:0] ALUControl;
    logic [3:0] Cond;
    logic       RdIsPC;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    RegWrite: 1'b0, MemWrite: 1'b0, MemtoReg: 1'b0, ALUSrc: 1'b0,
    Branch: 1'b0, FlagWrite: 2'b00, ALUControl: ALU_ADD,
    Cond: COND_AL, RdIsPC: 1'b0
  };

endpackage

// File: rtl/control_unit_pipe_cond_check.sv
// ARM condition-code evaluation against NZCV; 1111 never passes.
module cond_check
  import cu_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v, ge;
  assign {n, z, c, v} = Flags;
  assign ge = (n == v);

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~z & ge;
      COND_LE: CondEx = z | ~ge;
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit_pipe.sv
// Decode -> Execute control register with condition gating and NZCV flags.
// Define CU_MUL_EN to add the multi-cycle MUL decode and sequencer.
module control_unit_pipe
  import cu_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int MUL_LAT   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          InstrD,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic [3:0]           ALUFlagsE,
  output logic [1:0]           RegSrcD,
  output logic [1:0]           ImmSrcD,
  output logic                 ALUSrcE,
  output logic                 MemtoRegE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 PCSrcE,
  output logic                 CondExE,
  output logic [3:0]           FlagsQ,
  output logic                 MulBusyE
);

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cond, rd;
  logic       is_mul;
  logic [2:0] alu;
  logic       cmd_ok, cmp;
  ctrl_t      d, e;

  assign cond  = InstrD[31:28];
  assign op    = InstrD[27:26];
  assign funct = InstrD[25:20];
  assign rd    = InstrD[15:12];

`ifdef CU_MUL_EN
  assign is_mul = (op == 2'b00) && (funct[5:1] == 5'b00000) && (InstrD[7:4] == 4'b1001);
`else
  assign is_mul = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{InstrD[11:0]};

  always_comb begin
    d       = CTRL_BUBBLE;
    alu     = ALU_ADD;
    cmd_ok  = 1'b1;
    cmp     = 1'b0;
    RegSrcD = {(op == 2'b01) && !funct[0], op == 2'b10};
    ImmSrcD = (op == 2'b11) ? 2'b00 : op;
    case (funct[4:1])
      4'b0100: alu = ALU_ADD;
      4'b0010: alu = ALU_SUB;
      4'b0000: alu = ALU_AND;
      4'b1100: alu = ALU_ORR;
      4'b0001: alu = ALU_EOR;
      4'b1010: begin alu = ALU_SUB; cmp = 1'b1; end
      default: cmd_ok = 1'b0;
    endcase
    case (op)
      2'b00: begin
        if (is_mul) begin
          d.RegWrite   = 1'b1;
          d.ALUControl = ALU_MUL;
          d.FlagWrite  = {funct[0], 1'b0};
          d.RdIsPC     = (InstrD[19:16] == 4'hF);
          d.Cond       = cond;
        end else if (cmd_ok) begin
          // CMP always writes all flags and never the register file
          d.RegWrite   = !cmp;
          d.ALUSrc     = funct[5];
          d.ALUControl = alu;
          d.FlagWrite  = cmp ? 2'b11
                             : {funct[0], funct[0] && (alu == ALU_ADD || alu == ALU_SUB)};
          d.RdIsPC     = (rd == 4'hF);
          d.Cond       = cond;
        end
      end
      2'b01: begin
        d.RegWrite = funct[0];
        d.MemWrite = !funct[0];
        d.MemtoReg = funct[0];
        d.ALUSrc   = 1'b1;
        d.RdIsPC   = (rd == 4'hF);
        d.Cond     = cond;
      end
      2'b10: begin
        d.Branch = 1'b1;
        d.ALUSrc = 1'b1;
        d.Cond   = cond;
      end
      default: ;
    endcase
  end

  // A busy MUL owns Execute: flush is ignored and the word is held.
  always_ff @(posedge clk) begin
    if (reset || (FlushE && !MulBusyE)) e <= CTRL_BUBBLE;
    else if (!(StallE || MulBusyE))     e <= d;
  end

  cond_check u_cond (
    .Cond   (e.Cond),
    .Flags  (FlagsQ),
    .CondEx (CondExE)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      FlagsQ <= 4'b0000;
    end else begin
      if (e.FlagWrite[1] && CondExE && !MulBusyE) FlagsQ[3:2] <= ALUFlagsE[3:2];
      if (e.FlagWrite[0] && CondExE && !MulBusyE) FlagsQ[1:0] <= ALUFlagsE[1:0];
    end
  end

`ifdef CU_MUL_EN
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 2);
  mul_state_t state;
  logic [3:0] cnt;
  logic       mul_go;

  assign mul_go   = (e.ALUControl == ALU_MUL) && CondExE && (MUL_LAT > 1);
  assign MulBusyE = (state == BUSY) ? (cnt != 4'd0) : mul_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: if (mul_go) begin state <= BUSY; cnt <= CNT_INIT; end
        BUSY: if (cnt == 4'd0) state <= IDLE;
              else             cnt   <= cnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic [31:0] unused_lat;
  assign unused_lat = MUL_LAT;
  assign MulBusyE   = 1'b0;
`endif

  assign ALUSrcE     = e.ALUSrc;
  assign MemtoRegE   = e.MemtoReg;
  assign ALUControlE = ALUCTRL_W'(e.ALUControl);
  assign RegWriteE   = e.RegWrite & CondExE;
  assign MemWriteE   = e.MemWrite & CondExE;
  assign PCSrcE      = ((e.RdIsPC & e.RegWrite) | e.Branch) & CondExE;

endmodule
